// File: rtl/ms_io_fifo_port_if.sv
// ms_io_fifo_port_if: 16-bit-address IO port bus between core (master) and peripheral (slave).
interface ms_io_fifo_port_if;
  logic [15:0] AIoAddr;
  logic [63:0] AIoMosi;
  logic [3:0]  AIoWrSize;
  logic [3:0]  AIoRdSize;
  logic [63:0] AIoMiso;
  logic        AIoBusy;
  logic        AIoSrq;
  modport master (output AIoAddr, AIoMosi, AIoWrSize, AIoRdSize, input AIoMiso, AIoBusy, AIoSrq);
  modport slave (input AIoAddr, AIoMosi, AIoWrSize, AIoRdSize, output AIoMiso, AIoBusy, AIoSrq);
endinterface

// File: rtl/ms_io_fifo_port.sv
// ms_io_fifo_port: IO-bus mailbox FIFO (DATA/STAT/CTRL) with one-wait-state pops and level service request.
// Define MS_IO_FIFO_STAT_RC_EN to make a STAT read clear the sticky overflow/underflow flags.
module ms_io_fifo_port #(
  parameter logic [15:0] CBase     = 16'h0100,
  parameter int          CDepthLog = 4
) (
  input  logic              AClkH,
  input  logic              AResetHN,
  input  logic              AClkHEn,
  ms_io_fifo_port_if.slave  io
);
  localparam int Depth = 1 << CDepthLog;
  typedef logic [CDepthLog-1:0] ptr_t;
  typedef logic [CDepthLog:0]   cnt_t;
  logic [63:0] mem_q [Depth];
  ptr_t        wptr_q, wptr_d, rptr_q, rptr_d;
  cnt_t        cnt_q, cnt_d;
  logic [7:0]  thr_q, thr_d;
  logic [63:0] rd_word_q, rd_word_d;
  logic        srq_en_q, srq_en_d, ovf_q, ovf_d, udf_q, udf_d, rd_pend_q, rd_pend_d, srq_q;
  logic        sel_data, sel_stat, sel_ctrl, wr, rd, empty, full, push, pop, flush;
  logic [63:0] mask, stat, ctrl;
  assign sel_data = io.AIoAddr[15:3] == CBase[15:3];
  assign sel_stat = io.AIoAddr[15:3] == CBase[15:3] + 13'd1;
  assign sel_ctrl = io.AIoAddr[15:3] == CBase[15:3] + 13'd2;
  // a simultaneous write suppresses the read entirely
  assign wr = |io.AIoWrSize;
  assign rd = |io.AIoRdSize & ~wr;
  assign empty = cnt_q == '0;
  assign full = cnt_q == cnt_t'(Depth);
  assign push = wr & sel_data & ~full;
  assign pop = rd & sel_data & rd_pend_q & ~empty;
  assign flush = wr & sel_ctrl & io.AIoMosi[8];
  assign mask = io.AIoWrSize == 4'd1 ? 64'hff :
                io.AIoWrSize == 4'd2 ? 64'hffff :
                io.AIoWrSize == 4'd4 ? 64'hffff_ffff : '1;
  assign stat = {39'b0, srq_en_q, thr_q, 8'(cnt_q), 4'b0, udf_q, ovf_q, full, empty};
  assign ctrl = {54'b0, srq_en_q, 1'b0, thr_q};
  assign io.AIoMiso = rd & sel_stat ? stat :
                      rd & sel_ctrl ? ctrl :
                      rd & sel_data & rd_pend_q ? rd_word_q : '0;
  assign io.AIoBusy = rd & sel_data & ~rd_pend_q;
  assign io.AIoSrq = srq_q;
  always_comb begin
    wptr_d = flush ? '0 : wptr_q + ptr_t'(push);
    rptr_d = flush ? '0 : rptr_q + ptr_t'(pop);
    cnt_d = flush ? '0 : cnt_q + cnt_t'(push) - cnt_t'(pop);
    thr_d = wr & sel_ctrl ? io.AIoMosi[7:0] : thr_q;
    srq_en_d = wr & sel_ctrl ? io.AIoMosi[9] : srq_en_q;
    rd_pend_d = ~flush & rd & sel_data & ~rd_pend_q;
    rd_word_d = ~rd_pend_d ? rd_word_q : empty ? '0 : mem_q[rptr_q];
`ifdef MS_IO_FIFO_STAT_RC_EN
    ovf_d = ~flush & ~(rd & sel_stat) & (ovf_q | (wr & sel_data & full));
    udf_d = ~flush & ~(rd & sel_stat) & (udf_q | (rd & sel_data & rd_pend_q & empty));
`else
    ovf_d = ~flush & (ovf_q | (wr & sel_data & full));
    udf_d = ~flush & (udf_q | (rd & sel_data & rd_pend_q & empty));
`endif
  end
  always_ff @(posedge AClkH or negedge AResetHN)
    if (!AResetHN) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      thr_q <= '0;
      srq_en_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_word_q <= '0;
      srq_q <= 1'b0;
    end else if (AClkHEn) begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      thr_q <= thr_d;
      srq_en_q <= srq_en_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      rd_pend_q <= rd_pend_d;
      rd_word_q <= rd_word_d;
      srq_q <= srq_en_q & |thr_q & (9'(cnt_q) >= {1'b0, thr_q});
    end
  always_ff @(posedge AClkH)
    if (AClkHEn && push) mem_q[wptr_q] <= io.AIoMosi & mask;
endmodule

// File: tb/tb_ms_io_fifo_port.sv
// tb_ms_io_fifo_port: directed stimulus with a read-completion scoreboard for ms_io_fifo_port.
module tb_ms_io_fifo_port;
  localparam logic [15:0] DATA = 16'h0100, STAT = 16'h0108, CTRL = 16'h0110;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  always #5 clk = ~clk;
  ms_io_fifo_port_if io();
  ms_io_fifo_port #(.CBase(16'h0100), .CDepthLog(4)) dut (.AClkH(clk), .AResetHN(rst_n), .AClkHEn(en), .io(io));
  typedef struct {string n; logic [63:0] v;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;
  task automatic chk(string n, logic [63:0] a, logic [63:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", n, a, x);
    end
  endtask
  // completed read: request present, no write, no wait state
  always @(negedge clk)
    if (io.AIoRdSize != 0 && io.AIoWrSize == 0 && !io.AIoBusy) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_read: got %h want none", io.AIoMiso);
      end else begin
        e = sb.pop_front();
        chk(e.n, io.AIoMiso, e.v);
      end
    end
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(logic [15:0] a, logic [63:0] d, logic [3:0] s);
    io.AIoAddr = a;
    io.AIoMosi = d;
    io.AIoWrSize = s;
    @(posedge clk);
    #1 io.AIoWrSize = 0;
  endtask
  task automatic rd(string n, logic [15:0] a, logic [63:0] x, logic w);
    sb.push_back('{n, x});
    io.AIoAddr = a;
    io.AIoRdSize = 4'd8;
    @(negedge clk);
    chk({n, "_busy"}, 64'(io.AIoBusy), 64'(w));
    for (int i = 0; i < 3 && io.AIoBusy; i++) @(negedge clk);
    if (io.AIoBusy) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got busy stuck want release", n);
    end
    @(posedge clk);
    #1 io.AIoRdSize = 0;
  endtask
  initial begin
    io.AIoAddr = 0;
    io.AIoMosi = 0;
    io.AIoWrSize = 0;
    io.AIoRdSize = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_miso", io.AIoMiso, 0);
    chk("rst_busy", 64'(io.AIoBusy), 0);
    chk("rst_srq", 64'(io.AIoSrq), 0);
    rd("stat_rst", STAT, 64'h1, 0);
    wr(DATA, 64'h1122334455667788, 2);
    rd("data_sz2", DATA, 64'h7788, 1);
    rd("stat_empty", STAT, 64'h1, 0);
    for (int i = 0; i < 16; i++) wr(DATA, 64'(i), 8);
    wr(DATA, 64'hDEAD, 2);
    rd("stat_full", STAT, 64'h1006, 0);
`ifdef MS_IO_FIFO_STAT_RC_EN
    rd("stat_rc", STAT, 64'h1002, 0);
`else
    rd("stat_sticky", STAT, 64'h1006, 0);
`endif
    for (int i = 0; i < 16; i++) rd($sformatf("pop%0d", i), DATA, 64'(i), 1);
    rd("pop_empty", DATA, 0, 1);
`ifdef MS_IO_FIFO_STAT_RC_EN
    rd("stat_udf", STAT, 64'h9, 0);
`else
    rd("stat_udf", STAT, 64'hD, 0);
`endif
    wr(CTRL, 64'h204, 8);
    rd("ctrl_rd", CTRL, 64'h204, 0);
    for (int i = 0; i < 3; i++) wr(DATA, 64'(100 + i), 8);
    idle(2);
    chk("srq_3", 64'(io.AIoSrq), 0);
    wr(DATA, 64'd103, 8);
    chk("srq_lag", 64'(io.AIoSrq), 0);
    idle(1);
    chk("srq_4", 64'(io.AIoSrq), 1);
    rd("pop100", DATA, 64'd100, 1);
    idle(2);
    chk("srq_pop", 64'(io.AIoSrq), 0);
    wr(DATA, 64'd104, 8);
    wr(DATA, 64'd105, 8);
    idle(2);
    chk("srq_5", 64'(io.AIoSrq), 1);
    wr(CTRL, 64'h304, 8);
    idle(2);
    chk("srq_flush", 64'(io.AIoSrq), 0);
    rd("stat_flush", STAT, 64'h0104_0001, 0);
    rd("ctrl_keep", CTRL, 64'h204, 0);
    wr(DATA, 64'hA, 8);
    wr(DATA, 64'hB, 8);
    io.AIoAddr = DATA;
    io.AIoRdSize = 4'd8;
    @(negedge clk);
    chk("drop_busy", 64'(io.AIoBusy), 1);
    @(posedge clk);
    #1 io.AIoRdSize = 0;
    idle(1);
    rd("stat_drop", STAT, 64'h0104_0200, 0);
    rd("pop_A", DATA, 64'hA, 1);
    en = 1'b0;
    wr(DATA, 64'hC, 8);
    en = 1'b1;
    rd("stat_nce", STAT, 64'h0104_0100, 0);
    rd("pop_B", DATA, 64'hB, 1);
    io.AIoAddr = DATA;
    io.AIoMosi = 64'hE;
    io.AIoWrSize = 4'd8;
    io.AIoRdSize = 4'd8;
    @(negedge clk);
    chk("wr_rd_busy", 64'(io.AIoBusy), 0);
    chk("wr_rd_miso", io.AIoMiso, 0);
    @(posedge clk);
    #1 io.AIoWrSize = 0;
    io.AIoRdSize = 0;
    rd("pop_E", DATA, 64'hE, 1);
    wr(DATA, 64'h1122334455667788, 4);
    wr(DATA, 64'h1122334455667788, 3);
    wr(DATA, 64'h1122334455667788, 1);
    rd("sz4", DATA, 64'h5566_7788, 1);
    rd("sz3", DATA, 64'h1122334455667788, 1);
    rd("sz1", DATA, 64'h88, 1);
    rd("unmapped", 16'h0118, 0, 0);
    rd("stat_end", STAT, 64'h0104_0001, 0);
    idle(2);
    chk("sb_drain", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
